// File: rtl/scan_ctrl_pkg.sv
// Shared types and encodings for the scan chain controller.
// Imported by the controller top module.
package scan_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SHIFT   = 2'd1,
    CAPTURE = 2'd2,
    FLUSH   = 2'd3
  } state_t;

  // NbarT encodings seen by every chain cell
  localparam logic SCAN_SHIFT = 1'b1;
  localparam logic SCAN_FUNC  = 1'b0;

  // Counter width able to hold values 0..n
  function automatic int cnt_w(input int n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/scan_test_ctrl_if.sv
// Stimulus/response streams plus the chain-side scan signals of one scan chain.
// The master modport is the controller; the slave modport is the host/netlist side.
interface scan_test_ctrl_if;
  logic pat_valid;
  logic pat_bit;
  logic pat_ready;
  logic resp_valid;
  logic resp_bit;
  logic resp_ready;
  logic so;
  logic nbart;
  logic ce;
  logic si;

  modport master (
    input  pat_valid, pat_bit, resp_ready, so,
    output pat_ready, resp_valid, resp_bit, nbart, ce, si
  );

  modport slave (
    output pat_valid, pat_bit, resp_ready, so,
    input  pat_ready, resp_valid, resp_bit, nbart, ce, si
  );
endinterface

// File: rtl/scan_bit_counter.sv
// Up-counter that wraps to zero after reaching LAST and flags the terminal count.
// Used both for bit positions along the chain and for capture cycles.
module scan_bit_counter #(
  parameter int W    = 4,
  parameter int LAST = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic at_last
);

  localparam logic [W-1:0] LAST_V = W'(LAST);

  logic [W-1:0] cnt;

  assign at_last = (cnt == LAST_V);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= at_last ? '0 : cnt + W'(1);
    end
  end

endmodule

// File: rtl/scan_test_ctrl.sv
// Scan chain sequencer: loads stimulus, captures, and unloads responses with the
// unload of pattern n-1 overlapped on the load of pattern n, then a final flush.
module scan_test_ctrl
  import scan_ctrl_pkg::*;
#(
  parameter int CHAIN_LEN      = 8,
  parameter int CAPTURE_CYCLES = 1,
  parameter int PCNT_W         = 16
) (
  input  logic              C,
  input  logic              global_reset,
  input  logic              start,
  input  logic              abort,
  input  logic [PCNT_W-1:0] pattern_count,
  scan_test_ctrl_if.master  bus,
  output logic              busy,
  output logic              done,
  output logic              aborted
);

  localparam int BIT_W = cnt_w(CHAIN_LEN);
  localparam int CAP_W = cnt_w(CAPTURE_CYCLES);

  state_t            state;
  logic [PCNT_W-1:0] pat_left;
  logic              unload_en;
  logic              shift_go;
  logic              step;
  logic              bit_last;
  logic              cap_last;
  logic              bit_clr;
  logic              cap_clr;
  logic              cap_inc;

  // During overlapped load a stimulus bit may only enter when the bit it pushes out is taken
  assign shift_go = bus.pat_valid && (!unload_en || bus.resp_ready);

  always_comb begin
    step           = 1'b0;
    bus.nbart      = SCAN_FUNC;
    bus.ce         = 1'b0;
    bus.si         = 1'b0;
    bus.pat_ready  = 1'b0;
    bus.resp_valid = 1'b0;
    case (state)
      SHIFT: begin
        bus.nbart      = SCAN_SHIFT;
        bus.si         = bus.pat_bit;
        step           = shift_go && !abort;
        bus.ce         = step;
        bus.pat_ready  = step;
        bus.resp_valid = unload_en && bus.pat_valid && !abort;
      end
      CAPTURE: begin
        bus.ce = !abort;
      end
      FLUSH: begin
        bus.nbart      = SCAN_SHIFT;
        step           = bus.resp_ready && !abort;
        bus.ce         = step;
        bus.resp_valid = !abort;
      end
      default: ;
    endcase
  end

  assign bus.resp_bit = bus.so;
  assign busy         = (state != IDLE);

  assign bit_clr = abort || (state == IDLE);
  assign cap_clr = abort || (state != CAPTURE);
  assign cap_inc = (state == CAPTURE);

  scan_bit_counter #(.W(BIT_W), .LAST(CHAIN_LEN - 1)) u_bit_cnt (
    .clk     (C),
    .rst     (global_reset),
    .clr     (bit_clr),
    .inc     (step),
    .at_last (bit_last)
  );

  scan_bit_counter #(.W(CAP_W), .LAST(CAPTURE_CYCLES - 1)) u_cap_cnt (
    .clk     (C),
    .rst     (global_reset),
    .clr     (cap_clr),
    .inc     (cap_inc),
    .at_last (cap_last)
  );

  always_ff @(posedge C or posedge global_reset) begin
    if (global_reset) begin
      state     <= IDLE;
      pat_left  <= '0;
      unload_en <= 1'b0;
      done      <= 1'b0;
      aborted   <= 1'b0;
    end else begin
      done    <= 1'b0;
      aborted <= 1'b0;
      if (abort) begin
        state     <= IDLE;
        pat_left  <= '0;
        unload_en <= 1'b0;
        aborted   <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              if (pattern_count == '0) begin
                done <= 1'b1;
              end else begin
                pat_left  <= pattern_count;
                unload_en <= 1'b0;
                state     <= SHIFT;
              end
            end
          end
          SHIFT: begin
            if (step && bit_last) begin
              if (pat_left != '0) pat_left <= pat_left - PCNT_W'(1);
              state <= CAPTURE;
            end
          end
          CAPTURE: begin
            if (cap_last) begin
              unload_en <= 1'b1;
              state     <= (pat_left != '0) ? SHIFT : FLUSH;
            end
          end
          FLUSH: begin
            if (step && bit_last) begin
              unload_en <= 1'b0;
              done      <= 1'b1;
              state     <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_scan_test_ctrl.sv
// Bench for scan_test_ctrl: a behavioural 4-cell chain whose capture inverts every cell,
// so each unloaded response stream must equal the inverted stimulus stream in send order.
`timescale 1ns/1ps
module tb_scan_test_ctrl;
  localparam int N = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        start1, abort1, busy1, done1, aborted1;
  logic [15:0] pc1;
  logic        start2, abort2, busy2, done2, aborted2;
  logic [15:0] pc2;

  scan_test_ctrl_if bus1 ();
  scan_test_ctrl_if bus2 ();

  scan_test_ctrl #(.CHAIN_LEN(N), .CAPTURE_CYCLES(1), .PCNT_W(16)) dut1 (
    .C(clk), .global_reset(rst), .start(start1), .abort(abort1), .pattern_count(pc1),
    .bus(bus1.master), .busy(busy1), .done(done1), .aborted(aborted1));

  scan_test_ctrl #(.CHAIN_LEN(N), .CAPTURE_CYCLES(3), .PCNT_W(16)) dut2 (
    .C(clk), .global_reset(rst), .start(start2), .abort(abort2), .pattern_count(pc2),
    .bus(bus2.master), .busy(busy2), .done(done2), .aborted(aborted2));

  // Chain cells: bit 0 is fed by si, bit N-1 drives so; capture loads D = ~Q
  logic [N-1:0] chain1 = '0;
  logic [N-1:0] chain2 = '0;
  assign bus1.so = chain1[N-1];
  assign bus2.so = chain2[N-1];
  always @(posedge clk) if (bus1.ce) chain1 <= bus1.nbart ? {chain1[N-2:0], bus1.si} : ~chain1;
  always @(posedge clk) if (bus2.ce) chain2 <= bus2.nbart ? {chain2[N-2:0], bus2.si} : ~chain2;

  int checks = 0;
  int failures = 0;

  bit stim_src[$];
  bit stim_ref[$];
  bit stim_got[$];
  bit resp_got[$];
  int n_done, done_cyc, n_shift_ce, n_cap, n_bad, gap_hits, gap_moved, n_idle_act, timed_out;

  task automatic load_stim(input int nbits);
    bit b;
    stim_src.delete(); stim_ref.delete();
    for (int i = 0; i < nbits; i++) begin
      b = 1'($urandom);
      stim_src.push_back(b); stim_ref.push_back(b);
    end
  endtask

  // Drives one session on dut1 and records what crossed each interface.
  task automatic run_session(input int npat, input int vld_pct, input int rdy_pct,
                             input int gap_from, input int gap_len, input int max_cyc);
    int cyc, after;
    bit in_gap;
    logic [N-1:0] snap;
    stim_got.delete(); resp_got.delete();
    n_done = 0; done_cyc = -1; n_shift_ce = 0; n_cap = 0; n_bad = 0;
    gap_hits = 0; gap_moved = 0; n_idle_act = 0; timed_out = 0;
    snap = '0; cyc = 0; after = -1;
    @(negedge clk);
    pc1 = 16'(npat); start1 = 1'b1;
    forever begin
      in_gap = (cyc >= gap_from) && (cyc < gap_from + gap_len);
      bus1.pat_valid  = !in_gap && (stim_src.size() > 0) && (int'($urandom_range(99)) < vld_pct);
      bus1.pat_bit    = (stim_src.size() > 0) ? stim_src[0] : 1'b0;
      bus1.resp_ready = (int'($urandom_range(99)) < rdy_pct);
      #1;
      if (in_gap && cyc == gap_from) snap = chain1;
      if (in_gap && (bus1.ce || bus1.pat_ready)) gap_hits++;
      if (bus1.pat_ready) begin
        stim_got.push_back(bus1.pat_bit);
        if (stim_src.size() > 0) void'(stim_src.pop_front());
        if (!bus1.pat_valid) n_bad++;
        if (bus1.resp_valid && !bus1.resp_ready) n_bad++;
      end
      if (bus1.resp_valid && bus1.resp_ready) resp_got.push_back(bus1.resp_bit);
      if (bus1.nbart && bus1.ce) n_shift_ce++;
      if (busy1 && !bus1.nbart && bus1.ce) n_cap++;
      if (!busy1 && (bus1.nbart || bus1.ce || bus1.pat_ready || bus1.resp_valid)) n_idle_act++;
      if (done1) begin
        n_done++;
        if (done_cyc < 0) begin done_cyc = cyc; after = cyc + 2; end
      end
      @(negedge clk);
      if (gap_len > 0 && cyc == gap_from + gap_len - 1 && chain1 != snap) gap_moved = 1;
      start1 = 1'b0;
      if (cyc == 0) pc1 = 16'($urandom);
      cyc++;
      if (after >= 0 && cyc >= after) break;
      if (cyc >= max_cyc) begin timed_out = 1; break; end
    end
    bus1.pat_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++; if ({bus1.nbart, bus1.ce, bus1.si, bus1.pat_ready, bus1.resp_valid} !== 5'b0) begin
      failures++; $display("FAIL reset_scan_outs got=%b required=00000",
        {bus1.nbart, bus1.ce, bus1.si, bus1.pat_ready, bus1.resp_valid}); end
    checks++; if ({busy1, done1, aborted1, busy2, done2, aborted2} !== 6'b0) begin
      failures++; $display("FAIL reset_status got=%b required=000000",
        {busy1, done1, aborted1, busy2, done2, aborted2}); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_single_pattern();
    bit exp_resp [4];
    exp_resp = '{1'b0, 1'b1, 1'b0, 1'b0};
    stim_src = '{1'b1, 1'b0, 1'b1, 1'b1};
    stim_ref = stim_src;
    run_session(1, 100, 100, -10, 0, 50);
    checks++; if (timed_out !== 0) begin failures++; $display("FAIL single_timeout got=%0d required=0", timed_out); end
    checks++; if (done_cyc !== 10) begin failures++; $display("FAIL single_done_cycle got=%0d required=10", done_cyc); end
    checks++; if (n_done !== 1) begin failures++; $display("FAIL single_done_count got=%0d required=1", n_done); end
    checks++; if (n_shift_ce !== 8) begin failures++; $display("FAIL single_shift_cycles got=%0d required=8", n_shift_ce); end
    checks++; if (n_cap !== 1) begin failures++; $display("FAIL single_capture_cycles got=%0d required=1", n_cap); end
    checks++; if (resp_got.size() !== 4) begin failures++; $display("FAIL single_resp_count got=%0d required=4", resp_got.size()); end
    for (int i = 0; i < 4 && i < resp_got.size(); i++) begin
      checks++; if (resp_got[i] !== exp_resp[i]) begin failures++;
        $display("FAIL single_resp[%0d] got=%0d required=%0d", i, resp_got[i], exp_resp[i]); end
    end
  endtask

  task automatic test_reset_mid_shift();
    @(negedge clk);
    pc1 = 16'd1; start1 = 1'b1;
    bus1.pat_valid = 1'b1; bus1.pat_bit = 1'b1; bus1.resp_ready = 1'b1;
    @(negedge clk); start1 = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++; if ({busy1, bus1.nbart, bus1.ce} !== 3'b111) begin failures++;
      $display("FAIL pre_reset_shifting got=%b required=111", {busy1, bus1.nbart, bus1.ce}); end
    #1 rst = 1'b1;
    #1;
    checks++; if ({bus1.nbart, bus1.ce, bus1.si, bus1.pat_ready, bus1.resp_valid, busy1, done1, aborted1} !== 8'b0) begin
      failures++; $display("FAIL async_reset_outs got=%b required=00000000",
        {bus1.nbart, bus1.ce, bus1.si, bus1.pat_ready, bus1.resp_valid, busy1, done1, aborted1}); end
    @(negedge clk);
    rst = 1'b0; bus1.pat_valid = 1'b0;
    load_stim(N);
    run_session(1, 100, 100, -10, 0, 50);
    checks++; if (done_cyc !== 10) begin failures++; $display("FAIL after_reset_done_cycle got=%0d required=10", done_cyc); end
    for (int i = 0; i < N && i < resp_got.size(); i++) begin
      checks++; if (resp_got[i] !== ~stim_ref[i]) begin failures++;
        $display("FAIL after_reset_resp[%0d] got=%0d required=%0d", i, resp_got[i], ~stim_ref[i]); end
    end
  endtask

  task automatic test_valid_gap();
    load_stim(2 * N);
    run_session(2, 100, 100, 3, 3, 80);
    checks++; if (gap_hits !== 0) begin failures++; $display("FAIL gap_ce_or_ready got=%0d required=0", gap_hits); end
    checks++; if (gap_moved !== 0) begin failures++; $display("FAIL gap_chain_moved got=%0d required=0", gap_moved); end
    checks++; if (stim_got.size() !== 2 * N) begin failures++; $display("FAIL gap_stim_count got=%0d required=%0d", stim_got.size(), 2 * N); end
    checks++; if (resp_got.size() !== 2 * N) begin failures++; $display("FAIL gap_resp_count got=%0d required=%0d", resp_got.size(), 2 * N); end
    checks++; if (n_done !== 1) begin failures++; $display("FAIL gap_done_count got=%0d required=1", n_done); end
    for (int i = 0; i < 2 * N && i < resp_got.size(); i++) begin
      checks++; if (resp_got[i] !== ~stim_ref[i]) begin failures++;
        $display("FAIL gap_resp[%0d] got=%0d required=%0d", i, resp_got[i], ~stim_ref[i]); end
    end
  endtask

  task automatic test_back_pressure();
    for (int r = 0; r < 4; r++) begin
      int np;
      np = (r == 0) ? 2 : int'($urandom_range(3, 1));
      load_stim(np * N);
      run_session(np, (r == 0) ? 100 : 70, (r == 0) ? 50 : 60, -10, 0, 400);
      checks++; if (n_bad !== 0) begin failures++; $display("FAIL bp%0d_illegal_consume got=%0d required=0", r, n_bad); end
      checks++; if (timed_out !== 0) begin failures++; $display("FAIL bp%0d_timeout got=%0d required=0", r, timed_out); end
      checks++; if (n_done !== 1) begin failures++; $display("FAIL bp%0d_done_count got=%0d required=1", r, n_done); end
      checks++; if (resp_got.size() !== np * N) begin failures++;
        $display("FAIL bp%0d_resp_count got=%0d required=%0d", r, resp_got.size(), np * N); end
      checks++; if (stim_got.size() !== np * N) begin failures++;
        $display("FAIL bp%0d_stim_count got=%0d required=%0d", r, stim_got.size(), np * N); end
      for (int i = 0; i < np * N && i < resp_got.size(); i++) begin
        checks++; if (resp_got[i] !== ~stim_ref[i]) begin failures++;
          $display("FAIL bp%0d_resp[%0d] got=%0d required=%0d", r, i, resp_got[i], ~stim_ref[i]); end
      end
    end
  endtask

  task automatic test_zero_patterns();
    load_stim(0);
    run_session(0, 100, 100, -10, 0, 20);
    checks++; if (done_cyc !== 1) begin failures++; $display("FAIL zero_done_cycle got=%0d required=1", done_cyc); end
    checks++; if (n_done !== 1) begin failures++; $display("FAIL zero_done_count got=%0d required=1", n_done); end
    checks++; if (n_idle_act !== 0) begin failures++; $display("FAIL zero_idle_activity got=%0d required=0", n_idle_act); end
    checks++; if (n_shift_ce + n_cap !== 0) begin failures++; $display("FAIL zero_chain_clocked got=%0d required=0", n_shift_ce + n_cap); end
  endtask

  task automatic test_abort_capture();
    int k;
    int done_seen;
    done_seen = 0;
    @(negedge clk);
    pc2 = 16'd1; start2 = 1'b1;
    bus2.pat_valid = 1'b1; bus2.pat_bit = 1'($urandom); bus2.resp_ready = 1'b1;
    @(negedge clk); start2 = 1'b0;
    @(negedge clk); start2 = 1'b1; pc2 = 16'd0;
    #1 if (done2) done_seen++;
    @(negedge clk); start2 = 1'b0;
    for (k = 0; k < 20; k++) begin
      #1;
      if (done2) done_seen++;
      if (busy2 && !bus2.nbart) break;
      @(negedge clk);
    end
    checks++; if (k >= 20) begin failures++; $display("FAIL abort_reach_capture got=timeout required=capture"); end
    checks++; if (bus2.ce !== 1'b1) begin failures++; $display("FAIL abort_capture_ce got=%0d required=1", bus2.ce); end
    @(negedge clk);
    abort2 = 1'b1;
    #1;
    checks++; if ({bus2.ce, bus2.pat_ready, bus2.resp_valid} !== 3'b000) begin failures++;
      $display("FAIL abort_cycle_outs got=%b required=000", {bus2.ce, bus2.pat_ready, bus2.resp_valid}); end
    @(negedge clk);
    abort2 = 1'b0;
    #1;
    checks++; if ({aborted2, done2, busy2} !== 3'b100) begin failures++;
      $display("FAIL abort_next_cycle got=%b required=100", {aborted2, done2, busy2}); end
    @(negedge clk);
    #1;
    checks++; if ({aborted2, done2, busy2} !== 3'b000) begin failures++;
      $display("FAIL abort_pulse_width got=%b required=000", {aborted2, done2, busy2}); end
    checks++; if (done_seen !== 0) begin failures++; $display("FAIL abort_start_while_busy got=%0d required=0", done_seen); end
    bus2.pat_valid = 1'b0;
  endtask

  initial begin
    start1 = 1'b0; abort1 = 1'b0; pc1 = '0;
    start2 = 1'b0; abort2 = 1'b0; pc2 = '0;
    bus1.pat_valid = 1'b0; bus1.pat_bit = 1'b0; bus1.resp_ready = 1'b0;
    bus2.pat_valid = 1'b0; bus2.pat_bit = 1'b0; bus2.resp_ready = 1'b0;
    test_reset();
    test_single_pattern();
    test_reset_mid_shift();
    test_valid_gap();
    test_back_pressure();
    test_zero_patterns();
    test_abort_capture();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=running required=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
